// File: rtl/adc_capture.sv
// Dual-channel 14-bit ADC receive front end: registers both ports, converts codes to
// two's complement and emits a settled, period-indexed sample stream gated by sync_in.
module adc_capture #(
   parameter int SETTLE_CYCLES = 11,
   parameter bit OFFSET_BINARY = 1'b1
) (
   input  logic        CLK_65,
   input  logic        reset,
   input  logic        enable,
   input  logic [15:0] ptos_x_ciclo,
   input  logic        sync_in,
   input  logic [13:0] ADC_DA,
   input  logic [13:0] ADC_DB,
   input  logic        ADC_OTR_A,
   input  logic        ADC_OTR_B,
   output logic        ADC_CLK_A,
   output logic        ADC_CLK_B,
   output logic        ADC_OEB_A,
   output logic        ADC_OEB_B,
   output logic [13:0] data_a,
   output logic [13:0] data_b,
   output logic        data_valid,
   output logic        cycle_start,
   output logic [15:0] sample_idx,
   output logic        overrange
);

   localparam logic [15:0] SETTLE_N = 16'(SETTLE_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_SETTLE,
      S_RUN
   } state_t;

   function automatic logic [13:0] to_signed(input logic [13:0] code);
      if (OFFSET_BINARY) return {~code[13], code[12:0]};
      else               return code;
   endfunction

   // Stage 1: raw pin capture
   logic [13:0] da_q, da_d, db_q, db_d;
   logic        otr_a_q, otr_a_d, otr_b_q, otr_b_d;
   logic        sync_d1_q, sync_d1_d;

   // Control
   state_t      state_q, state_d;
   logic [15:0] period_q, period_d;
   logic [15:0] settle_cnt_q, settle_cnt_d;
   logic [15:0] idx_next_q, idx_next_d;
   logic        emit;

   // Stage 2: outputs
   logic [13:0] data_a_q, data_a_d, data_b_q, data_b_d;
   logic        data_valid_q, data_valid_d;
   logic        cycle_start_q, cycle_start_d;
   logic [15:0] sample_idx_q, sample_idx_d;
   logic        overrange_q, overrange_d;

   // NOTE: every signal gets a default at the top of always_comb so no path infers a latch.
   always_comb begin
      da_d          = ADC_DA;
      db_d          = ADC_DB;
      otr_a_d       = ADC_OTR_A;
      otr_b_d       = ADC_OTR_B;
      sync_d1_d     = sync_in;

      state_d       = state_q;
      period_d      = period_q;
      settle_cnt_d  = settle_cnt_q;
      idx_next_d    = idx_next_q;
      emit          = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (enable) begin
               state_d      = S_ARMED;
               period_d     = ptos_x_ciclo;
               settle_cnt_d = '0;
               idx_next_d   = '0;
            end
         end
         S_ARMED: begin
            if (sync_d1_q) begin
               settle_cnt_d = 16'd1;
               if (SETTLE_CYCLES == 0) begin
                  state_d = S_RUN;
                  emit    = 1'b1;
               end else if (SETTLE_CYCLES == 1) begin
                  state_d = S_RUN;
               end else begin
                  state_d = S_SETTLE;
               end
            end
         end
         S_SETTLE: begin
            if (sync_d1_q) begin
               settle_cnt_d = settle_cnt_q + 16'd1;
               if (settle_cnt_d == SETTLE_N) state_d = S_RUN;
            end
         end
         S_RUN: begin
            emit = sync_d1_q;
         end
         default: state_d = S_IDLE;
      endcase

      // Dropping enable wins over every transition; only a RUN sample already qualified survives.
      if (!enable) begin
         state_d = S_IDLE;
         emit    = emit && (state_q == S_RUN);
      end

      data_a_d      = data_a_q;
      data_b_d      = data_b_q;
      sample_idx_d  = sample_idx_q;
      overrange_d   = overrange_q;
      data_valid_d  = emit;
      cycle_start_d = emit && (idx_next_q == 16'd0);

      if (emit) begin
         data_a_d     = to_signed(da_q);
         data_b_d     = to_signed(db_q);
         sample_idx_d = idx_next_q;
         overrange_d  = overrange_q | otr_a_q | otr_b_q;
         if (period_q <= 16'd1 || idx_next_q == period_q - 16'd1) idx_next_d = '0;
         else                                                     idx_next_d = idx_next_q + 16'd1;
      end

      if (!enable || state_q == S_IDLE) overrange_d = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge CLK_65 or posedge reset) begin
      if (reset) begin
         da_q          <= '0;
         db_q          <= '0;
         otr_a_q       <= 1'b0;
         otr_b_q       <= 1'b0;
         sync_d1_q     <= 1'b0;
         state_q       <= S_IDLE;
         period_q      <= '0;
         settle_cnt_q  <= '0;
         idx_next_q    <= '0;
         data_a_q      <= '0;
         data_b_q      <= '0;
         data_valid_q  <= 1'b0;
         cycle_start_q <= 1'b0;
         sample_idx_q  <= '0;
         overrange_q   <= 1'b0;
      end else begin
         da_q          <= da_d;
         db_q          <= db_d;
         otr_a_q       <= otr_a_d;
         otr_b_q       <= otr_b_d;
         sync_d1_q     <= sync_d1_d;
         state_q       <= state_d;
         period_q      <= period_d;
         settle_cnt_q  <= settle_cnt_d;
         idx_next_q    <= idx_next_d;
         data_a_q      <= data_a_d;
         data_b_q      <= data_b_d;
         data_valid_q  <= data_valid_d;
         cycle_start_q <= cycle_start_d;
         sample_idx_q  <= sample_idx_d;
         overrange_q   <= overrange_d;
      end
   end

   assign ADC_CLK_A   = CLK_65;
   assign ADC_CLK_B   = CLK_65;
   assign ADC_OEB_A   = 1'b0;
   assign ADC_OEB_B   = 1'b0;

   assign data_a      = data_a_q;
   assign data_b      = data_b_q;
   assign data_valid  = data_valid_q;
   assign cycle_start = cycle_start_q;
   assign sample_idx  = sample_idx_q;
   assign overrange   = overrange_q;

endmodule

// File: tb/tb_adc_capture.sv
// Scoreboard bench for adc_capture: one instance without settling (conversion, period 1)
// and one with the default 11-sample settle (discard, wrap, gaps, overrange, reset, enable).
module tb_adc_capture;

   typedef struct packed {
      logic [13:0] a;
      logic [13:0] b;
      logic [15:0] idx;
      logic        cs;
      logic        ov;
   } exp_t;

   logic        clk = 1'b0;
   always #8 clk = ~clk;

   logic        reset, en0, en1, sync_in, otr_a, otr_b;
   logic [15:0] ptos;
   logic [13:0] da, db;

   logic        clk_a0, clk_b0, oeb_a0, oeb_b0, dv0, cs0, ov0;
   logic        clk_a1, clk_b1, oeb_a1, oeb_b1, dv1, cs1, ov1;
   logic [13:0] data_a0, data_b0, data_a1, data_b1;
   logic [15:0] idx0, idx1;

   exp_t        q0[$];
   exp_t        q1[$];
   logic        hold_chk;
   logic [13:0] last_a1, last_b1;
   int          n_checks = 0;
   int          n_errors = 0;

   adc_capture #(.SETTLE_CYCLES(0), .OFFSET_BINARY(1'b1)) u_dut0 (
      .CLK_65(clk), .reset(reset), .enable(en0), .ptos_x_ciclo(ptos), .sync_in(sync_in),
      .ADC_DA(da), .ADC_DB(db), .ADC_OTR_A(otr_a), .ADC_OTR_B(otr_b),
      .ADC_CLK_A(clk_a0), .ADC_CLK_B(clk_b0), .ADC_OEB_A(oeb_a0), .ADC_OEB_B(oeb_b0),
      .data_a(data_a0), .data_b(data_b0), .data_valid(dv0), .cycle_start(cs0),
      .sample_idx(idx0), .overrange(ov0)
   );

   adc_capture #(.SETTLE_CYCLES(11), .OFFSET_BINARY(1'b1)) u_dut1 (
      .CLK_65(clk), .reset(reset), .enable(en1), .ptos_x_ciclo(ptos), .sync_in(sync_in),
      .ADC_DA(da), .ADC_DB(db), .ADC_OTR_A(otr_a), .ADC_OTR_B(otr_b),
      .ADC_CLK_A(clk_a1), .ADC_CLK_B(clk_b1), .ADC_OEB_A(oeb_a1), .ADC_OEB_B(oeb_b1),
      .data_a(data_a1), .data_b(data_b1), .data_valid(dv1), .cycle_start(cs1),
      .sample_idx(idx1), .overrange(ov1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [13:0] a, input logic [13:0] b, input logic s,
                        input logic oa, input logic ob);
      da = a; db = b; sync_in = s; otr_a = oa; otr_b = ob;
      step();
   endtask

   task automatic push0(input logic [13:0] a, input logic [13:0] b, input logic [15:0] idx,
                        input logic cs, input logic ov);
      exp_t e;
      e.a = a; e.b = b; e.idx = idx; e.cs = cs; e.ov = ov;
      q0.push_back(e);
   endtask

   task automatic push1(input logic [13:0] a, input logic [13:0] b, input logic [15:0] idx,
                        input logic cs, input logic ov);
      exp_t e;
      e.a = a; e.b = b; e.idx = idx; e.cs = cs; e.ov = ov;
      q1.push_back(e);
   endtask

   always @(negedge clk) begin : mon0
      exp_t e;
      if (dv0) begin
         if (q0.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL dut0_unexpected_valid: got data_a=0x%0h, expected no sample", data_a0);
         end else begin
            e = q0.pop_front();
            check("dut0_data_a", 32'(data_a0), 32'(e.a));
            check("dut0_data_b", 32'(data_b0), 32'(e.b));
            check("dut0_sample_idx", 32'(idx0), 32'(e.idx));
            check("dut0_cycle_start", 32'(cs0), 32'(e.cs));
            check("dut0_overrange", 32'(ov0), 32'(e.ov));
         end
      end
   end

   always @(negedge clk) begin : mon1
      exp_t e;
      if (dv1) begin
         if (q1.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL dut1_unexpected_valid: got data_a=0x%0h, expected no sample", data_a1);
         end else begin
            e = q1.pop_front();
            check("dut1_data_a", 32'(data_a1), 32'(e.a));
            check("dut1_data_b", 32'(data_b1), 32'(e.b));
            check("dut1_sample_idx", 32'(idx1), 32'(e.idx));
            check("dut1_cycle_start", 32'(cs1), 32'(e.cs));
            check("dut1_overrange", 32'(ov1), 32'(e.ov));
            last_a1 = e.a;
            last_b1 = e.b;
         end
      end else if (hold_chk) begin
         check("dut1_hold_a", 32'(data_a1), 32'(last_a1));
         check("dut1_hold_b", 32'(data_b1), 32'(last_b1));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, expected finish before 200000 ns");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [13:0] cva[4], cvb[4], cea[4], ceb[4];
      logic [13:0] pa[3], pb[3], pea[3], peb[3];
      logic [13:0] kk;

      cva = '{14'h0000, 14'h2000, 14'h3FFF, 14'h1234};
      cvb = '{14'h3FFF, 14'h0000, 14'h2001, 14'h0ABC};
      cea = '{14'h2000, 14'h0000, 14'h1FFF, 14'h3234};
      ceb = '{14'h1FFF, 14'h2000, 14'h0001, 14'h2ABC};
      pa  = '{14'h0001, 14'h2ABC, 14'h3000};
      pb  = '{14'h1FFF, 14'h2000, 14'h0010};
      pea = '{14'h2001, 14'h0ABC, 14'h1000};
      peb = '{14'h3FFF, 14'h0000, 14'h2010};

      reset = 1'b1; en0 = 1'b0; en1 = 1'b0; sync_in = 1'b0; otr_a = 1'b0; otr_b = 1'b0;
      ptos = 16'd16; da = '0; db = '0; hold_chk = 1'b0; last_a1 = '0; last_b1 = '0;

      // Reset state and static pin outputs
      repeat (3) step();
      check("rst_dv0", 32'(dv0), 32'd0);
      check("rst_data_a0", 32'(data_a0), 32'd0);
      check("rst_idx0", 32'(idx0), 32'd0);
      check("rst_cs0", 32'(cs0), 32'd0);
      check("rst_ov0", 32'(ov0), 32'd0);
      check("rst_dv1", 32'(dv1), 32'd0);
      check("rst_data_b1", 32'(data_b1), 32'd0);
      check("rst_ov1", 32'(ov1), 32'd0);
      check("adc_clk_hi", 32'({clk_a0, clk_b0, clk_a1, clk_b1}), 32'({4{clk}}));
      check("adc_oeb", 32'({oeb_a0, oeb_b0, oeb_a1, oeb_b1}), 32'd0);
      @(negedge clk); #1;
      check("adc_clk_lo", 32'({clk_a0, clk_b0, clk_a1, clk_b1}), 32'({4{clk}}));
      step();
      reset = 1'b0;
      step();

      // Conversion, no settling
      en0 = 1'b1;
      repeat (3) step();
      for (int i = 0; i < 4; i++) begin
         push0(cea[i], ceb[i], 16'(i), i == 0, 1'b0);
         drive(cva[i], cvb[i], 1'b1, 1'b0, 1'b0);
      end
      repeat (3) drive('0, '0, 1'b0, 1'b0, 1'b0);
      en0 = 1'b0;
      repeat (2) step();

      // Period of one: every sample starts a cycle
      ptos = 16'd1;
      en0  = 1'b1;
      repeat (3) step();
      for (int i = 0; i < 3; i++) begin
         push0(pea[i], peb[i], 16'd0, 1'b1, 1'b0);
         drive(pa[i], pb[i], 1'b1, 1'b0, 1'b0);
      end
      repeat (3) drive('0, '0, 1'b0, 1'b0, 1'b0);
      en0 = 1'b0;
      step();

      // Settle discard, period-4 wrap, overrange during settle and in run
      ptos = 16'd4;
      en1  = 1'b1;
      repeat (4) step();
      for (int k = 0; k < 20; k++) begin
         kk = 14'(k);
         if (k >= 11)
            push1(14'h2100 + kk, 14'h1000 + kk, 16'((k - 11) % 4), ((k - 11) % 4) == 0, k >= 15);
         drive(14'h0100 + kk, 14'h3000 + kk, 1'b1, 1'b0, (k == 5) || (k == 15));
      end

      // Gapped qualifier 1,0,0,1 with data hold
      hold_chk = 1'b1;
      push1(14'h1111, 14'h2222, 16'd1, 1'b0, 1'b1);
      drive(14'h3111, 14'h0222, 1'b1, 1'b0, 1'b0);
      drive(14'h0555, 14'h0666, 1'b0, 1'b0, 1'b0);
      drive(14'h0777, 14'h0888, 1'b0, 1'b0, 1'b0);
      push1(14'h3333, 14'h0444, 16'd2, 1'b0, 1'b1);
      drive(14'h1333, 14'h2444, 1'b1, 1'b0, 1'b0);
      repeat (3) drive('0, '0, 1'b0, 1'b0, 1'b0);
      hold_chk = 1'b0;

      // Enable low clears the sticky flag
      en1 = 1'b0;
      repeat (2) step();
      check("idle_ov1", 32'(ov1), 32'd0);
      check("idle_dv1", 32'(dv1), 32'd0);

      // Re-arm with period 8; later period change must be ignored
      ptos = 16'd8;
      en1  = 1'b1;
      repeat (2) step();
      ptos = 16'd2;
      for (int k = 0; k < 14; k++) begin
         kk = 14'(k);
         if (k >= 11) push1(14'h2AA0 + kk, kk, 16'(k - 11), k == 11, 1'b0);
         drive(14'h0AA0 + kk, 14'h2000 + kk, 1'b1, 1'b0, 1'b0);
      end
      drive('0, '0, 1'b0, 1'b0, 1'b0);
      @(negedge clk); #2;
      check("pre_reset_idx1", 32'(idx1), 32'd2);
      reset = 1'b1;
      #1;
      check("async_rst_dv1", 32'(dv1), 32'd0);
      check("async_rst_data_a1", 32'(data_a1), 32'd0);
      check("async_rst_data_b1", 32'(data_b1), 32'd0);
      check("async_rst_idx1", 32'(idx1), 32'd0);
      check("async_rst_cs1", 32'(cs1), 32'd0);
      check("async_rst_ov1", 32'(ov1), 32'd0);
      en1 = 1'b0;
      repeat (2) step();
      reset = 1'b0;
      step();

      // Fresh arming after reset repeats the full settle
      ptos = 16'd8;
      en1  = 1'b1;
      repeat (2) step();
      for (int k = 0; k < 13; k++) begin
         kk = 14'(k);
         if (k >= 11) push1(14'h2F00 + kk, 14'h1F00 + kk, 16'(k - 11), k == 11, 1'b0);
         drive(14'h0F00 + kk, 14'h3F00 + kk, 1'b1, 1'b0, 1'b0);
      end

      // Enable dropped mid-run: the qualified sample still leaves, nothing after it
      push1(14'h0222, 14'h3111, 16'd2, 1'b0, 1'b0);
      drive(14'h2222, 14'h1111, 1'b1, 1'b0, 1'b0);
      en1 = 1'b0;
      drive(14'h3FFF, 14'h3FFF, 1'b1, 1'b0, 1'b0);
      drive(14'h1000, 14'h1000, 1'b1, 1'b0, 1'b0);
      repeat (3) drive('0, '0, 1'b0, 1'b0, 1'b0);

      check("dut0_queue_empty", 32'(q0.size()), 32'd0);
      check("dut1_queue_empty", 32'(q1.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/adc_capture.md
# adc_capture

Receive-side front end for the dual-channel 14-bit high-speed ADC, the counterpart of the DAC output path on the same 65 MHz clock. Registers both ADC ports and converts offset-binary codes to signed two's complement. Waits for the DAC's `data_valid_dac_export` synchronisation pulse stream, discards a fixed number of settling samples, then emits a qualified sample stream with per-period indexing for downstream processing (lock-in, averaging).

## Interface
Parameters:
- `SETTLE_CYCLES`, default 11: number of qualified samples discarded after arming. 0 means no discard.
- `OFFSET_BINARY`, default 1: 1 means invert the MSB (offset-binary to two's complement); 0 means pass codes through unchanged.

Ports:
- `CLK_65`  in  1: sample clock, all logic on the rising edge.
- `reset`  in  1: asynchronous, active-high. Clears all state.
- `enable`  in  1: run control; low forces IDLE.
- `ptos_x_ciclo`  in  16: samples per signal period, latched on leaving IDLE.
- `sync_in`  in  1: sample qualifier, driven by `data_valid_dac_export`.
- `ADC_DA`, `ADC_DB`  in  14 each: ADC port A/B data.
- `ADC_OTR_A`, `ADC_OTR_B`  in  1 each: ADC out-of-range flags.
- `ADC_CLK_A`, `ADC_CLK_B`  out  1: equal to `CLK_65` (combinational).
- `ADC_OEB_A`, `ADC_OEB_B`  out  1: constant 0 (outputs always enabled).
- `data_a`, `data_b`  out  14: signed samples.
- `data_valid`  out  1: qualifies `data_a`/`data_b`.
- `cycle_start`  out  1: high with the first sample of each period.
- `sample_idx`  out  16: index of the current sample within the period.
- `overrange`  out  1: sticky out-of-range flag.

## Operation
- Stage 1 registers `ADC_DA`, `ADC_DB`, the OTR flags and `sync_in`; the registered qualifier is `sync_d1`. Stage 2 holds the outputs. The FSM acts on `sync_d1`.
- Conversion with `OFFSET_BINARY=1`, as `{~d[13], d[12:0]}`:
  - 0x0000 gives 0x2000 (-8192).
  - 0x2000 (mid-scale) gives 0.
  - 0x3FFF gives 0x1FFF (+8191).
- FSM states, each evaluated per edge:
  - IDLE: if `enable` is high, go to ARMED and latch `ptos_x_ciclo` into `period`.
  - ARMED: if `sync_d1` is high, go to SETTLE with `settle_cnt` = 1. If `SETTLE_CYCLES` ≤ 1, go directly to RUN instead. If `SETTLE_CYCLES` = 0, the arming sample is emitted in the same edge.
  - SETTLE: each edge with `sync_d1` high increments `settle_cnt`. The edge on which the count reaches `SETTLE_CYCLES` goes to RUN. Settling samples are never emitted.
  - RUN: each edge with `sync_d1` high emits a sample. Edges with `sync_d1` low emit nothing (`data_valid` 0, data holds) and do not change state.
  - Any state: `enable` low goes to IDLE on the next edge, takes priority over all other transitions, and clears `overrange`.
- `sample_idx`:
  - 0 on the first emitted sample after arming.
  - Increments on each emitted sample and wraps to 0 after `period`-1.
  - If `period` ≤ 1 it stays at 0.
  - Holds its value between valid samples.
- `cycle_start` equals `data_valid` && (`sample_idx` == 0), registered with the sample.
- `overrange` is set on an emitted sample whose registered OTR_A or OTR_B is 1. It is cleared only by `reset` or IDLE. Discarded samples never set it.
- Changes to `ptos_x_ciclo` outside IDLE are ignored until the next arming.

## Timing
- Reset values: state IDLE, all counters 0, `data_a`/`data_b` 0, `data_valid`, `cycle_start`, `sample_idx` and `overrange` all 0.
- Latency: ADC pins and `sync_in` sampled at edge n appear on the outputs after edge n+1 (2 register stages).
- `data_valid` is a single-cycle strobe per sample. There is no backpressure; consumers must accept every valid sample.
- Reset asserted mid-RUN: outputs clear asynchronously. After release, the block returns to IDLE and needs a fresh arming/settle sequence.
- `enable` deasserted mid-RUN: the sample qualified on that edge is still emitted. From the next edge on, `data_valid` is 0.

## Test plan
- Conversion: `ADC_DA` = 0x0000/0x2000/0x3FFF, `SETTLE_CYCLES`=0, `sync_in` held high → `data_a` = 0x2000/0x0000/0x1FFF, 2 edges after each drive.
- Settle discard: `SETTLE_CYCLES`=11, `enable` high, `sync_in` high from cycle 5, ramp on `ADC_DA` → first `data_valid` carries the 12th qualified ramp value, `sample_idx`=0, `cycle_start`=1.
- Period wrap: `ptos_x_ciclo`=4, continuous sync → `sample_idx` 0,1,2,3,0,…, `cycle_start` every 4th sample. Repeat with `ptos_x_ciclo`=1 → `cycle_start` on every sample.
- Gapped sync: in RUN, `sync_in` toggles 1,0,0,1 → two valid samples with consecutive indices, and data holds during the gap.
- Overrange: `ADC_OTR_B`=1 during SETTLE → `overrange` stays 0. `ADC_OTR_B`=1 on one RUN sample → `overrange`=1 and sticky. `enable` low → cleared.
- Reset/enable mid-RUN: assert `reset` at `sample_idx`=2 → all outputs 0 immediately. Re-enable → full settle repeats and index restarts at 0.
